// File: rtl/dmem_dump_unit.sv
// End-of-program result extractor: on PC reaching END_PC, reads a window of
// data-memory words through a second read port and streams them out.
module dmem_dump_unit #(
    parameter logic [31:0] END_PC    = 32'h0000_008c,
    parameter int          BASE_WORD = 32,
    parameter int          COUNT     = 96,
    parameter int          LINE_LEN  = 16,
    parameter int          MEM_AW    = 8,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_line_end,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    // state     | meaning
    // S_IDLE    | waiting for pc == END_PC
    // S_READ    | read strobe to port B for word BASE_WORD+idx
    // S_WAIT    | read data arrives, captured at the edge
    // S_PRESENT | word offered on the dump stream until accepted
    // S_DONE    | window delivered; sticky until reset

    if (COUNT < 1 || BASE_WORD + COUNT > (2 ** MEM_AW) ||
        LINE_LEN < 2 || (LINE_LEN & (LINE_LEN - 1)) != 0) begin : g_bad_param
        $error("dmem_dump_unit: illegal COUNT/BASE_WORD/LINE_LEN parameters");
    end

    localparam int IDX_W = $clog2(COUNT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [31:0]        idx_ext;
    logic               is_last;
    logic               is_line_end;

    assign idx_ext     = 32'(idx_q);
    assign is_last     = (idx_q == IDX_W'(COUNT - 1));
    assign is_line_end = (((idx_ext + 32'd1) & 32'(LINE_LEN - 1)) == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        data_d        = data_q;
        mem_rd_en     = 1'b0;
        mem_addr      = '0;
        dump_valid    = 1'b0;
        dump_line_end = 1'b0;
        dump_last     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pc == END_PC) begin
                    state_d = S_READ;
                    idx_d   = '0;
                end
            end
            S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = MEM_AW'(32'(BASE_WORD) + idx_ext);
                busy      = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                busy    = 1'b1;
                data_d  = mem_rdata;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                busy          = 1'b1;
                dump_valid    = 1'b1;
                dump_line_end = is_line_end;
                dump_last     = is_last;
                if (dump_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dump_data = data_q;

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Self-checking bench for dmem_dump_unit: vector table, hand-written corner
// sequences, and randomized backpressure against a memory-window model.
module tb_dmem_dump_unit;

    localparam logic [31:0] END_PC    = 32'h0000_008c;
    localparam int          BASE_WORD = 32;
    localparam int          COUNT     = 96;
    localparam int          LINE_LEN  = 16;
    localparam int          MEM_AW    = 8;
    localparam int          DATA_W    = 32;

    logic              clk;
    logic              reset;
    logic [31:0]       pc;
    logic              mem_rd_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] dump_data;
    logic              dump_valid;
    logic              dump_ready;
    logic              dump_line_end;
    logic              dump_last;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mem [2**MEM_AW];

    dmem_dump_unit #(
        .END_PC(END_PC), .BASE_WORD(BASE_WORD), .COUNT(COUNT),
        .LINE_LEN(LINE_LEN), .MEM_AW(MEM_AW), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_line_end(dump_line_end), .dump_last(dump_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous read port B of the data memory
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        rdy;
        logic        rd_en;
        logic        chk_addr;
        logic [7:0]  addr;
        logic        valid;
        logic [31:0] data;
        logic        le;
        logic        last;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pc         = 32'd0;
        dump_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < 2**MEM_AW; i++) mem[i] = 32'hA000_0000 + i;
    endtask

    // Runs a whole dump from the trigger edge, comparing every handshake with
    // the memory window and checking stream stability and post-done silence.
    task automatic run_dump(input int duty, input bit hold_pc, input int budget);
        int cyc, hs, rds, first_valid;
        bit rdy, prev_stall;
        logic [31:0] prev_data;
        logic prev_le, prev_last;
        pc         = END_PC;
        dump_ready = (duty >= 100);
        @(posedge clk);
        #1;
        cyc = 0; hs = 0; rds = 0; first_valid = -1; prev_stall = 0;
        prev_data = '0; prev_le = 0; prev_last = 0;
        if (!hold_pc) pc = 32'd0;
        while (!done && cyc < budget) begin
            if (mem_rd_en) begin
                chk("rd_addr", 32'(mem_addr), BASE_WORD + rds);
                if (rds == 0) chk("first_rd_cycle", cyc, 0);
                rds++;
            end
            if (prev_stall) begin
                chk("stall_valid", dump_valid, 1'b1);
                chk("stall_data", dump_data, prev_data);
                chk("stall_line_end", dump_line_end, prev_le);
                chk("stall_last", dump_last, prev_last);
            end
            if (dump_valid && first_valid < 0) begin
                first_valid = cyc;
                chk("first_valid_cycle", cyc, 2);
            end
            rdy = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            dump_ready = rdy;
            if (dump_valid && rdy) begin
                chk("word_data", dump_data, mem[BASE_WORD + hs]);
                chk("word_line_end", dump_line_end, (hs % LINE_LEN) == LINE_LEN - 1);
                chk("word_last", dump_last, hs == COUNT - 1);
                hs++;
            end
            prev_stall = dump_valid && !rdy;
            prev_data  = dump_data;
            prev_le    = dump_line_end;
            prev_last  = dump_last;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("dump_done", done, 1'b1);
        chk("handshakes", hs, COUNT);
        chk("reads", rds, COUNT);
        if (duty >= 100) chk("done_cycle", cyc, COUNT * 3);
        pc = END_PC;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("post_done", {28'd0, done, busy, mem_rd_en, dump_valid}, 32'b1000);
        end
        pc = 32'd0;
        dump_ready = 1'b0;
    endtask

    initial begin
        int hs, cyc;
        reset = 1'b1; pc = 32'd0; dump_ready = 1'b0;
        preload_ramp();

        //          rst pc          rdy rd  ca addr v  data            le last busy done
        vecs[0]  = '{1, 32'h00,     0,  0,  1, 8'd0,  0, 32'h0,          0, 0, 0, 0};
        vecs[1]  = '{0, 32'h00,     0,  0,  1, 8'd0,  0, 32'h0,          0, 0, 0, 0};
        vecs[2]  = '{0, 32'h88,     0,  0,  1, 8'd0,  0, 32'h0,          0, 0, 0, 0};
        vecs[3]  = '{0, 32'h8c,     0,  1,  1, 8'd32, 0, 32'h0,          0, 0, 1, 0};
        vecs[4]  = '{0, 32'h00,     0,  0,  0, 8'd0,  0, 32'h0,          0, 0, 1, 0};
        vecs[5]  = '{0, 32'h00,     0,  0,  0, 8'd0,  1, 32'hA000_0020,  0, 0, 1, 0};
        vecs[6]  = '{0, 32'h8c,     0,  0,  0, 8'd0,  1, 32'hA000_0020,  0, 0, 1, 0};
        vecs[7]  = '{0, 32'h00,     1,  1,  1, 8'd33, 0, 32'h0,          0, 0, 1, 0};
        vecs[8]  = '{0, 32'h00,     1,  0,  0, 8'd0,  0, 32'h0,          0, 0, 1, 0};
        vecs[9]  = '{0, 32'h00,     1,  0,  0, 8'd0,  1, 32'hA000_0021,  0, 0, 1, 0};
        vecs[10] = '{0, 32'h00,     0,  0,  0, 8'd0,  1, 32'hA000_0021,  0, 0, 1, 0};
        vecs[11] = '{1, 32'h00,     0,  0,  1, 8'd0,  0, 32'h0,          0, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            reset      = vecs[i].rst;
            pc         = vecs[i].pc;
            dump_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk("vec_rd_en", mem_rd_en, vecs[i].rd_en);
            if (vecs[i].chk_addr) chk("vec_addr", 32'(mem_addr), 32'(vecs[i].addr));
            chk("vec_valid", dump_valid, vecs[i].valid);
            if (vecs[i].valid || vecs[i].rst) begin
                chk("vec_data", dump_data, vecs[i].data);
                chk("vec_line_end", dump_line_end, vecs[i].le);
                chk("vec_last", dump_last, vecs[i].last);
            end
            chk("vec_busy", busy, vecs[i].busy);
            chk("vec_done", done, vecs[i].done);
        end

        // reset, then pc sweep below END_PC never starts a dump
        do_reset();
        for (int a = 0; a <= 32'h88; a += 4) begin
            pc = a;
            @(posedge clk);
            #1;
            chk("sweep_idle", {29'd0, mem_rd_en, busy, done}, 32'd0);
        end

        // full dump, ready tied high
        run_dump(100, 1'b0, 2000);

        // backpressure on word 0
        do_reset();
        pc = END_PC;
        @(posedge clk);
        #1 pc = 32'd0;
        cyc = 0;
        while (!dump_valid && cyc < 10) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("bp_valid_seen", dump_valid, 1'b1);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", dump_valid, 1'b1);
            chk("bp_hold_data", dump_data, 32'hA000_0020);
            chk("bp_no_read", mem_rd_en, 1'b0);
        end
        dump_ready = 1'b1;
        @(posedge clk);
        #1 dump_ready = 1'b0;
        chk("bp_adv_read", mem_rd_en, 1'b1);
        chk("bp_adv_addr", 32'(mem_addr), 32'd33);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_word1", dump_data, 32'hA000_0021);
        chk("bp_word1_valid", dump_valid, 1'b1);

        // pc held at END_PC throughout and after the dump
        do_reset();
        run_dump(100, 1'b1, 2000);

        // asynchronous reset after the 40th handshake
        do_reset();
        pc = END_PC;
        dump_ready = 1'b1;
        @(posedge clk);
        #1 pc = 32'd0;
        hs = 0; cyc = 0;
        while (hs < 40 && cyc < 1000) begin
            if (dump_valid) hs++;
            @(posedge clk);
            #1 cyc++;
        end
        chk("mid_handshakes", hs, 40);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outs",
            {25'd0, mem_rd_en, dump_valid, dump_line_end, dump_last, busy, done, |mem_addr},
            32'd0);
        chk("async_rst_data", dump_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_dump(100, 1'b0, 2000);

        // randomized memory contents, 30% ready duty
        do_reset();
        for (int i = 0; i < 2**MEM_AW; i++) mem[i] = $urandom;
        run_dump(30, 1'b0, 8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
